spi_flash_arbiter: RTL and testbench

Shares the single spi_flash_controller between two requesters: the CPU bus port and a secondary DMA/boot-copy port. It queues one request per port, arbitrates, drives the controller's one-shot chip-enable and command fields, and waits for o_MemoryReady. It returns read data and a done strobe to the owner, and holds the CPU in HALT while a CPU access is outstanding. It sits between the CPU bus decode and the flash controller.

---
 rtl/spi_flash_pkg.sv | 24 ++
 rtl/spi_req_slot.sv | 32 +++
 rtl/spi_flash_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types for the SPI flash arbiter: FSM states, owners, request bundle.
package spi_flash_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_READY,
      ST_DONE
   } state_t;

   typedef enum logic {
      OWN_CPU,
      OWN_DMA
   } owner_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              rw;
   } flash_req_t;
endpackage

// File: rtl/spi_req_slot.sv
// One-deep request holding register with pending flag, one per requester.
module spi_req_slot
   import spi_flash_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_req,
   input  logic       i_busy,
   input  logic       i_clr,
   input  flash_req_t i_data,
   output logic       o_pending,
   output flash_req_t o_data
);
   logic       r_pending;
   flash_req_t r_data;

   // i_busy blocks capture while this port's access is on the wire (not in DONE)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= 1'b0;
         r_data    <= '0;
      end else if (i_clr) begin
         r_pending <= 1'b0;
      end else if (i_req && !r_pending && !i_busy) begin
         r_pending <= 1'b1;
         r_data    <= i_data;
      end
   end

   assign o_pending = r_pending;
   assign o_data    = r_data;
endmodule

// File: rtl/spi_flash_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of the single SPI flash controller.
module spi_flash_arbiter
   import spi_flash_pkg::*;
#(
   parameter int               CPU_STREAK_MAX = 4,
   parameter int               TIMEOUT_CYCLES = 4096,
   parameter logic [DATA_W-1:0] ERR_DATA      = 8'hFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_rw,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_halt,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_rw,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_done,
   output logic              fc_ce,
   output logic [ADDR_W-1:0] fc_addr,
   output logic [DATA_W-1:0] fc_wdata,
   output logic              fc_rw,
   input  logic [DATA_W-1:0] fc_rdata,
   input  logic              fc_ready,
   output logic              timeout_err
);
   localparam int SW = $clog2(CPU_STREAK_MAX + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   state_t            r_state, w_next;
   owner_t            r_owner;
   logic [SW-1:0]     r_streak;
   logic [TW-1:0]     r_tcnt;
   logic [TW-1:0]     w_tcnt_nxt;
   flash_req_t        r_fc;
   logic [DATA_W-1:0] r_cpu_rdata, r_dma_rdata;
   logic              r_cpu_done, r_dma_done, r_terr;

   flash_req_t w_cpu_in, w_dma_in, w_cpu_hold, w_dma_hold;
   logic       w_cpu_pend, w_dma_pend;
   logic       w_dma_win, w_gnt_cpu, w_gnt_dma;
   logic       w_wait, w_flight, w_tmo, w_abort, w_fin;

   assign w_cpu_in = '{addr: cpu_addr, wdata: cpu_wdata, rw: cpu_rw};
   assign w_dma_in = '{addr: dma_addr, wdata: dma_wdata, rw: dma_rw};

   spi_req_slot u_cpu_slot (
      .clk       (clk),
      .reset     (reset),
      .i_req     (cpu_req),
      .i_busy    (w_flight && r_owner == OWN_CPU),
      .i_clr     (w_gnt_cpu),
      .i_data    (w_cpu_in),
      .o_pending (w_cpu_pend),
      .o_data    (w_cpu_hold)
   );

   spi_req_slot u_dma_slot (
      .clk       (clk),
      .reset     (reset),
      .i_req     (dma_req),
      .i_busy    (w_flight && r_owner == OWN_DMA),
      .i_clr     (w_gnt_dma),
      .i_data    (w_dma_in),
      .o_pending (w_dma_pend),
      .o_data    (w_dma_hold)
   );

   // DMA is forced through once the CPU has had its streak
   assign w_dma_win  = w_dma_pend &&
                       (!w_cpu_pend || r_streak == SW'(CPU_STREAK_MAX));
   assign w_gnt_dma  = (r_state == ST_IDLE) && w_dma_win;
   assign w_gnt_cpu  = (r_state == ST_IDLE) && w_cpu_pend && !w_dma_win;
   assign w_wait     = (r_state == ST_WAIT_BUSY) ||
                       (r_state == ST_WAIT_READY);
   assign w_flight   = (r_state == ST_ISSUE) || w_wait;
   assign w_tcnt_nxt = r_tcnt + TW'(1);
   assign w_tmo      = w_wait && (w_tcnt_nxt == TW'(TIMEOUT_CYCLES - 1));
   assign w_abort    = w_tmo && !(r_state == ST_WAIT_READY && fc_ready);
   assign w_fin      = w_wait && (w_next == ST_DONE);

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:       if (w_gnt_cpu || w_gnt_dma) w_next = ST_ISSUE;
         ST_ISSUE:      w_next = ST_WAIT_BUSY;
         ST_WAIT_BUSY:  if (w_tmo) w_next = ST_DONE;
                        else if (!fc_ready) w_next = ST_WAIT_READY;
         ST_WAIT_READY: if (fc_ready || w_tmo) w_next = ST_DONE;
         ST_DONE:       w_next = ST_IDLE;
         default:       w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      fc_ce    = (r_state == ST_ISSUE);
      cpu_halt = w_cpu_pend ||
                 (r_owner == OWN_CPU && r_state != ST_IDLE);
   end

   // Strobes and read data are registered on entry to DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner     <= OWN_CPU;
         r_streak    <= '0;
         r_tcnt      <= '0;
         r_fc        <= '{addr: '0, wdata: '0, rw: 1'b1};
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
         r_cpu_done  <= 1'b0;
         r_dma_done  <= 1'b0;
         r_terr      <= 1'b0;
      end else begin
         r_cpu_done <= 1'b0;
         r_dma_done <= 1'b0;
         r_terr     <= 1'b0;
         if (w_gnt_cpu) begin
            r_owner <= OWN_CPU;
            r_fc    <= w_cpu_hold;
            r_tcnt  <= '0;
            if (r_streak != SW'(CPU_STREAK_MAX))
               r_streak <= r_streak + SW'(1);
         end
         if (w_gnt_dma) begin
            r_owner  <= OWN_DMA;
            r_fc     <= w_dma_hold;
            r_tcnt   <= '0;
            r_streak <= '0;
         end
         if (w_wait) r_tcnt <= w_tcnt_nxt;
         if (w_fin) begin
            r_terr <= w_abort;
            unique case (1'b1)
               (r_owner == OWN_CPU): begin
                  r_cpu_done <= 1'b1;
                  if (w_abort)      r_cpu_rdata <= ERR_DATA;
                  else if (r_fc.rw) r_cpu_rdata <= fc_rdata;
               end
               (r_owner == OWN_DMA): begin
                  r_dma_done <= 1'b1;
                  if (w_abort)      r_dma_rdata <= ERR_DATA;
                  else if (r_fc.rw) r_dma_rdata <= fc_rdata;
               end
               default: ;
            endcase
         end
      end
   end

   assign fc_addr     = r_fc.addr;
   assign fc_wdata    = r_fc.wdata;
   assign fc_rw       = r_fc.rw;
   assign cpu_rdata   = r_cpu_rdata;
   assign dma_rdata   = r_dma_rdata;
   assign cpu_done    = r_cpu_done;
   assign dma_done    = r_dma_done;
   assign timeout_err = r_terr;
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Randomised bench for spi_flash_arbiter with a transaction-level reference model.
module tb_spi_flash_arbiter;
   localparam int T    = 40;
   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_rw, dma_req, dma_rw;
   logic [15:0] cpu_addr, dma_addr;
   logic [7:0]  cpu_wdata, dma_wdata;
   logic [7:0]  cpu_rdata, dma_rdata, fc_rdata, fc_wdata;
   logic        cpu_done, cpu_halt, dma_done, fc_ce, fc_rw;
   logic        fc_ready, timeout_err;
   logic [15:0] fc_addr;

   always #5 clk = ~clk;

   spi_flash_arbiter #(.CPU_STREAK_MAX(SMAX), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rw(cpu_rw), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
      .cpu_halt(cpu_halt),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rw(dma_rw), .dma_rdata(dma_rdata), .dma_done(dma_done),
      .fc_ce(fc_ce), .fc_addr(fc_addr), .fc_wdata(fc_wdata), .fc_rw(fc_rw),
      .fc_rdata(fc_rdata), .fc_ready(fc_ready), .timeout_err(timeout_err)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
      logic        rw;
   } rq_t;

   int n_vec, n_err;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   bit          pend[2];
   rq_t         hold[2];
   rq_t         cur;
   int          streak, owner, mode, ctl_d, ctl_l, tdl;
   bit          busy, done_last, dn_prev, exp_done, exp_abort, armed;
   logic [7:0]  nxt_rdata;
   logic [7:0]  m_rdata[2];
   int          glog[$];
   int          n_ce_obs, n_cdone_obs;

   // One clock of the reference model; inputs were set by the caller
   task automatic step();
      bit  pb[2];
      bit  bb, rb, cr, dr, dnp, dn, ce_e;
      rq_t cq, dq;
      int  w;
      pb[0] = pend[0]; pb[1] = pend[1];
      bb = busy; rb = reset; dnp = dn_prev;
      cr = cpu_req; dr = dma_req;
      cq = {cpu_addr, cpu_wdata, cpu_rw};
      dq = {dma_addr, dma_wdata, dma_rw};
      @(negedge clk);
      if (fc_ce) n_ce_obs++;
      if (cpu_done) n_cdone_obs++;
      if (rb) begin
         pend[0] = 0; pend[1] = 0; busy = 0; done_last = 0; dn_prev = 0;
         exp_done = 0; exp_abort = 0; armed = 0; streak = 0; owner = 0;
         cur = {16'h0, 8'h0, 1'b1}; m_rdata[0] = 0; m_rdata[1] = 0;
         fc_ready = 1'b1;
         chk("rst_ce", fc_ce, 0);
         chk("rst_cdone", cpu_done, 0);
         chk("rst_ddone", dma_done, 0);
         chk("rst_terr", timeout_err, 0);
         chk("rst_halt", cpu_halt, 0);
         chk("rst_rw", fc_rw, 1);
         chk("rst_addr", fc_addr, 0);
         chk("rst_wdata", fc_wdata, 0);
         chk("rst_crd", cpu_rdata, 0);
         chk("rst_drd", dma_rdata, 0);
         return;
      end
      ce_e = !bb && (pb[0] || pb[1]);
      if (done_last) begin busy = 0; done_last = 0; end
      chk("fc_ce", fc_ce, ce_e);
      if (ce_e) begin
         w = (pb[1] && (!pb[0] || streak == SMAX)) ? 1 : 0;
         owner = w; cur = hold[w]; pend[w] = 0; busy = 1;
         streak = w ? 0 : (streak < SMAX ? streak + 1 : SMAX);
         glog.push_back(w);
         fc_rdata = nxt_rdata; armed = 1; tdl = T;
         ctl_d = $urandom_range(1, 3); ctl_l = $urandom_range(1, 4);
      end
      if (cr && !pb[0] && !(bb && owner == 0 && !dnp)) begin
         pend[0] = 1; hold[0] = cq;
      end
      if (dr && !pb[1] && !(bb && owner == 1 && !dnp)) begin
         pend[1] = 1; hold[1] = dq;
      end
      dn = exp_done; exp_done = 0;
      chk("cpu_done", cpu_done, dn && owner == 0);
      chk("dma_done", dma_done, dn && owner == 1);
      chk("timeout_err", timeout_err, dn && exp_abort);
      if (dn) begin
         if (exp_abort) m_rdata[owner] = 8'hFF;
         else if (cur.rw) m_rdata[owner] = fc_rdata;
         done_last = 1;
      end
      dn_prev = dn;
      chk("cpu_rdata", cpu_rdata, m_rdata[0]);
      chk("dma_rdata", dma_rdata, m_rdata[1]);
      chk("fc_addr", fc_addr, cur.a);
      chk("fc_wdata", fc_wdata, cur.d);
      chk("fc_rw", fc_rw, cur.rw);
      chk("cpu_halt", cpu_halt, pend[0] || (busy && owner == 0));
      fc_ready = 1'b1;
      if (armed) begin
         case (mode)
            0: if (ctl_d > 0) ctl_d--;
               else if (ctl_l > 0) begin fc_ready = 1'b0; ctl_l--; end
               else begin armed = 0; exp_done = 1; exp_abort = 0; end
            1: begin
               tdl--;
               if (tdl == 0) begin armed = 0; exp_done = 1; exp_abort = 1; end
            end
            default: if (ctl_d > 0) ctl_d = 0; else fc_ready = 1'b0;
         endcase
      end
   endtask

   task automatic cpu_go(input logic [15:0] a, input logic [7:0] d,
                         input logic rw);
      cpu_req = 1; cpu_addr = a; cpu_wdata = d; cpu_rw = rw;
      step();
      cpu_req = 0;
   endtask

   task automatic dma_go(input logic [15:0] a, input logic [7:0] d,
                         input logic rw);
      dma_req = 1; dma_addr = a; dma_wdata = d; dma_rw = rw;
      step();
      dma_req = 0;
   endtask

   task automatic settle();
      int k = 0;
      while ((busy || pend[0] || pend[1] || exp_done) && k < 300) begin
         step(); k++;
      end
      chk("settle_bound", k < 300, 1);
      step();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1);
   end

   initial begin
      int c0, d0, k;
      bit fired;
      int exp_seq[10];
      exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      reset = 1; cpu_req = 0; dma_req = 0; cpu_rw = 1; dma_rw = 1;
      cpu_addr = 0; dma_addr = 0; cpu_wdata = 0; dma_wdata = 0;
      fc_ready = 1; fc_rdata = 0; mode = 0; nxt_rdata = 0;
      step(); step();
      reset = 0;
      step();

      nxt_rdata = 8'hFA; glog.delete(); d0 = n_cdone_obs;
      cpu_go(16'h3AAA, 8'h00, 1);
      settle();
      chk("t1_grants", glog.size(), 1);
      chk("t1_rdata", cpu_rdata, 8'hFA);
      chk("t1_done_cnt", n_cdone_obs - d0, 1);
      chk("t1_halt_after", cpu_halt, 0);

      nxt_rdata = 8'h5A;
      dma_go(16'h3000, 8'hAA, 0);
      settle();
      chk("t2_wdata", fc_wdata, 8'hAA);
      chk("t2_rw", fc_rw, 0);
      chk("t2_drdata", dma_rdata, 8'h00);

      glog.delete(); fired = 0; k = 0;
      cpu_req = 1; cpu_rw = 1; dma_req = 1; dma_rw = 1;
      step();
      dma_req = 0;
      while (glog.size() < 10 && k < 600) begin
         cpu_addr = 16'($urandom); nxt_rdata = 8'($urandom);
         if (!fired && glog.size() == 6) begin
            dma_req = 1; step(); dma_req = 0; fired = 1;
         end else step();
         k++;
      end
      cpu_req = 0;
      chk("t3_bound", k < 600, 1);
      for (int i = 0; i < 10 && i < glog.size(); i++)
         chk($sformatf("t3_grant%0d", i), glog[i], exp_seq[i]);
      settle();

      mode = 1;
      cpu_go(16'h1234, 8'h00, 1);
      settle();
      mode = 0;
      chk("t4_rdata", cpu_rdata, 8'hFF);

      mode = 2; glog.delete(); k = 0;
      cpu_go(16'h2222, 8'h55, 1);
      while (glog.size() == 0 && k < 20) begin step(); k++; end
      chk("t5_grant", glog.size(), 1);
      step(); step();
      mode = 0; reset = 1;
      step();
      reset = 0;
      chk("t5_halt", cpu_halt, 0);
      chk("t5_done", cpu_done, 0);
      nxt_rdata = 8'h3C;
      cpu_go(16'h2222, 8'h55, 1);
      settle();
      chk("t5_rdata", cpu_rdata, 8'h3C);

      c0 = n_ce_obs; d0 = n_cdone_obs;
      cpu_go(16'h4444, 8'h11, 0);
      cpu_go(16'h5555, 8'h22, 1);
      step(); step();
      cpu_go(16'h6666, 8'h33, 1);
      settle();
      chk("t6_ce_cnt", n_ce_obs - c0, 1);
      chk("t6_done_cnt", n_cdone_obs - d0, 1);
      chk("t6_addr", fc_addr, 16'h4444);

      repeat (3000) begin
         cpu_req = ($urandom_range(0, 3) == 0);
         cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
         cpu_rw = 1'($urandom);
         dma_req = ($urandom_range(0, 3) == 0);
         dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
         dma_rw = 1'($urandom);
         nxt_rdata = 8'($urandom);
         step();
      end
      cpu_req = 0; dma_req = 0;
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
